// File: rtl/router_reg_param.sv
// router_reg_param: router packet datapath register with header capture, full-stall hold buffer,
// configurable parity/checksum accumulation and error reporting.
module router_reg_param #(
   parameter int DATA_W     = 8,
   parameter int HOLD_DEPTH = 2,
   parameter int CHK_MODE   = 0,
   parameter int ERRCNT_W   = 8
) (
   input  logic                clock,
   input  logic                resetn,
   input  logic                pkt_valid,
   input  logic [DATA_W-1:0]   data_in,
   input  logic                fifo_full,
   input  logic                detect_add,
   input  logic                lfd_state,
   input  logic                ld_state,
   input  logic                laf_state,
   input  logic                full_state,
   input  logic                rst_int_reg,
   output logic [DATA_W-1:0]   dout,
   output logic                parity_done,
   output logic                low_pkt_valid,
   output logic                err,
   output logic                hold_empty,
   output logic                hold_ovf,
   output logic [ERRCNT_W-1:0] err_count
);
   localparam int AW = HOLD_DEPTH > 1 ? $clog2(HOLD_DEPTH) : 1;
   localparam int CW = $clog2(HOLD_DEPTH + 1);

   logic [DATA_W-1:0] header, acc, chk;
   logic [DATA_W:0]   mem [HOLD_DEPTH];
   logic [AW-1:0]     wr, rd;
   logic [CW-1:0]     cnt;
   logic [DATA_W:0]   head;
   logic              is_da, is_lfd, is_laf, is_ld, pop, hold_full, err_n;

   function automatic logic [DATA_W-1:0] op(input logic [DATA_W-1:0] a, b);
      return CHK_MODE == 1 ? a + b : a ^ b;
   endfunction

   function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
      return (p == AW'(HOLD_DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   always_comb begin
      is_da     = detect_add;
      is_lfd    = !detect_add && lfd_state;
      is_laf    = !detect_add && !lfd_state && laf_state;
      is_ld     = !detect_add && !lfd_state && !laf_state && ld_state;
      head      = mem[rd];
      pop       = is_laf && !hold_empty;
      hold_full = cnt == CW'(HOLD_DEPTH);
      err_n     = parity_done && (acc != chk);
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         header        <= '0;
         acc           <= '0;
         chk           <= '0;
         dout          <= '0;
         parity_done   <= 1'b0;
         low_pkt_valid <= 1'b0;
         err           <= 1'b0;
         hold_empty    <= 1'b1;
         hold_ovf      <= 1'b0;
         err_count     <= '0;
         wr            <= '0;
         rd            <= '0;
         cnt           <= '0;
      end else begin
         if (pkt_valid && detect_add) header <= data_in;
         if (is_ld && !pkt_valid) low_pkt_valid <= 1'b1;
         else if (rst_int_reg) low_pkt_valid <= 1'b0;
         if (is_da) begin
            acc         <= '0;
            chk         <= '0;
            parity_done <= 1'b0;
            err         <= 1'b0;
            wr          <= '0;
            rd          <= '0;
            cnt         <= '0;
            hold_empty  <= 1'b1;
         end else begin
            err <= err_n;
            if (err_n && !err && err_count != '1) err_count <= err_count + ERRCNT_W'(1);
            if (is_lfd) begin
               dout <= header;
               acc  <= header;
            end else if (pop) begin
               dout       <= head[DATA_W-1:0];
               rd         <= inc(rd);
               cnt        <= cnt - CW'(1);
               hold_empty <= cnt == CW'(1);
               // tag bit marks the check byte, which must not enter the accumulator
               if (head[DATA_W]) begin
                  chk         <= head[DATA_W-1:0];
                  parity_done <= 1'b1;
               end else acc <= op(acc, head[DATA_W-1:0]);
            end else if (is_ld) begin
               if (!fifo_full) begin
                  dout <= data_in;
                  if (pkt_valid) acc <= op(acc, data_in);
                  else begin
                     chk         <= data_in;
                     parity_done <= 1'b1;
                  end
               end else if (hold_full) hold_ovf <= 1'b1;
               else begin
                  mem[wr]    <= {!pkt_valid, data_in};
                  wr         <= inc(wr);
                  cnt        <= cnt + CW'(1);
                  hold_empty <= 1'b0;
               end
            end else if (rst_int_reg && !pkt_valid && !full_state) acc <= '0;
         end
      end
   end
endmodule

// File: tb/tb_router_reg_param.sv
// tb_router_reg_param: directed bench driving XOR and additive instances with identical stimulus.
module tb_router_reg_param;
   logic clock = 0, resetn = 0, pkt_valid = 0, fifo_full = 0, detect_add = 0;
   logic lfd_state = 0, ld_state = 0, laf_state = 0, full_state = 0, rst_int_reg = 0;
   logic [7:0] data_in = 0;
   logic [7:0] dout0, dout1, ec0, ec1;
   logic pd0, pd1, lpv0, lpv1, err0, err1, he0, he1, ovf0, ovf1;
   int nvec = 0, nerr = 0, cnt0 = 0, cnt1 = 0;
   logic [7:0] exp_q[$];

   router_reg_param #(.CHK_MODE(0)) u0 (
      .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in), .fifo_full(fifo_full),
      .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state),
      .full_state(full_state), .rst_int_reg(rst_int_reg), .dout(dout0), .parity_done(pd0),
      .low_pkt_valid(lpv0), .err(err0), .hold_empty(he0), .hold_ovf(ovf0), .err_count(ec0));

   router_reg_param #(.CHK_MODE(1)) u1 (
      .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in), .fifo_full(fifo_full),
      .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state),
      .full_state(full_state), .rst_int_reg(rst_int_reg), .dout(dout1), .parity_done(pd1),
      .low_pkt_valid(lpv1), .err(err1), .hold_empty(he1), .hold_ovf(ovf1), .err_count(ec1));

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic both(input string tag, input logic [31:0] o0, o1, e0, e1);
      chk({tag, "_x"}, o0, e0);
      chk({tag, "_a"}, o1, e1);
   endtask

   task automatic step(input logic da, lfd, ld, laf, full, rsti, pv, ff, input logic [7:0] d);
      logic [7:0] e;
      detect_add = da; lfd_state = lfd; ld_state = ld; laf_state = laf;
      full_state = full; rst_int_reg = rsti; pkt_valid = pv; fifo_full = ff; data_in = d;
      @(posedge clock); #1;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         both("dout", dout0, dout1, e, e);
      end
   endtask

   task automatic reset_chk();
      both("rst_dout", dout0, dout1, 0, 0);
      both("rst_pd", pd0, pd1, 0, 0);
      both("rst_lpv", lpv0, lpv1, 0, 0);
      both("rst_err", err0, err1, 0, 0);
      both("rst_he", he0, he1, 1, 1);
      both("rst_ovf", ovf0, ovf1, 0, 0);
      both("rst_ecnt", ec0, ec1, 0, 0);
   endtask

   // after parity_done: one cycle for err, then confirm it holds and the count does not move again
   task automatic err_chk(input logic e0, e1);
      step(0, 0, 0, 0, 0, 1, 1, 0, 8'h00);
      if (e0 && cnt0 < 255) cnt0++;
      if (e1 && cnt1 < 255) cnt1++;
      both("err", err0, err1, e0, e1);
      both("ecnt", ec0, ec1, cnt0, cnt1);
      both("lpv_clr", lpv0, lpv1, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
      both("err_hold", err0, err1, e0, e1);
      both("ecnt_hold", ec0, ec1, cnt0, cnt1);
   endtask

   task automatic send_pkt(input logic [7:0] h, p1, p2, c);
      logic [7:0] x, s;
      x = h ^ p1 ^ p2;
      s = h + p1 + p2;
      step(1, 0, 0, 0, 0, 0, 1, 0, h);
      exp_q.push_back(h);
      step(0, 1, 0, 0, 0, 0, 1, 0, 8'h00);
      exp_q.push_back(p1);
      step(0, 0, 1, 0, 0, 0, 1, 0, p1);
      exp_q.push_back(p2);
      step(0, 0, 1, 0, 0, 0, 1, 0, p2);
      both("pd_pre", pd0, pd1, 0, 0);
      exp_q.push_back(c);
      step(0, 0, 1, 0, 0, 0, 0, 0, c);
      both("pd", pd0, pd1, 1, 1);
      both("lpv", lpv0, lpv1, 1, 1);
      err_chk(x != c, s != c);
   endtask

   initial begin
      step(0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
      reset_chk();
      resetn = 1;
      send_pkt(8'h05, 8'h11, 8'h22, 8'h36);
      send_pkt(8'h05, 8'h11, 8'h22, 8'h38);
      send_pkt(8'h05, 8'h11, 8'h22, 8'h39);
      // fifo goes full on the last payload byte; it and the check byte are held then drained
      step(1, 0, 0, 0, 0, 0, 1, 0, 8'h05);
      exp_q.push_back(8'h05);
      step(0, 1, 0, 0, 0, 0, 1, 0, 8'h00);
      exp_q.push_back(8'h11);
      step(0, 0, 1, 0, 0, 0, 1, 0, 8'h11);
      step(0, 0, 1, 0, 0, 0, 1, 1, 8'h22);
      both("hold_he", he0, he1, 0, 0);
      both("hold_dout", dout0, dout1, 8'h11, 8'h11);
      step(0, 0, 1, 0, 0, 0, 0, 1, 8'h36);
      both("hold_pd", pd0, pd1, 0, 0);
      both("hold_ovf", ovf0, ovf1, 0, 0);
      step(0, 0, 0, 0, 1, 0, 0, 1, 8'h00);
      both("full_dout", dout0, dout1, 8'h11, 8'h11);
      exp_q.push_back(8'h22);
      step(0, 0, 0, 1, 0, 0, 0, 0, 8'h00);
      both("laf1_pd", pd0, pd1, 0, 0);
      both("laf1_he", he0, he1, 0, 0);
      exp_q.push_back(8'h36);
      step(0, 0, 0, 1, 0, 0, 0, 0, 8'h00);
      both("laf2_pd", pd0, pd1, 1, 1);
      both("laf2_he", he0, he1, 1, 1);
      err_chk(1'b0, 1'b1);
      // third push into a two-entry buffer is dropped
      step(1, 0, 0, 0, 0, 0, 1, 0, 8'h05);
      exp_q.push_back(8'h05);
      step(0, 1, 0, 0, 0, 0, 1, 0, 8'h00);
      step(0, 0, 1, 0, 0, 0, 1, 1, 8'hA1);
      step(0, 0, 1, 0, 0, 0, 1, 1, 8'hA2);
      both("ovf_pre", ovf0, ovf1, 0, 0);
      step(0, 0, 1, 0, 0, 0, 1, 1, 8'hA3);
      both("ovf", ovf0, ovf1, 1, 1);
      step(1, 0, 0, 0, 0, 0, 1, 0, 8'h07);
      both("ovf_sticky", ovf0, ovf1, 1, 1);
      both("ovf_he", he0, he1, 1, 1);
      // short bad packets drive both counters into saturation
      for (int i = 0; i < 260; i++) begin
         step(1, 0, 0, 0, 0, 0, 1, 0, 8'h05);
         exp_q.push_back(8'h05);
         step(0, 1, 0, 0, 0, 0, 1, 0, 8'h00);
         exp_q.push_back(8'h00);
         step(0, 0, 1, 0, 0, 0, 0, 0, 8'h00);
         step(0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
         if (cnt0 < 255) cnt0++;
         if (cnt1 < 255) cnt1++;
      end
      both("sat", ec0, ec1, 8'hFF, 8'hFF);
      both("sat_err", err0, err1, 1, 1);
      // reset in the middle of a packet with a byte held
      step(1, 0, 0, 0, 0, 0, 1, 0, 8'h05);
      exp_q.push_back(8'h05);
      step(0, 1, 0, 0, 0, 0, 1, 0, 8'h00);
      step(0, 0, 1, 0, 0, 0, 1, 1, 8'h11);
      both("mid_he", he0, he1, 0, 0);
      resetn = 0;
      step(0, 0, 0, 0, 0, 0, 1, 0, 8'h00);
      reset_chk();
      resetn = 1;
      cnt0 = 0;
      cnt1 = 0;
      send_pkt(8'h05, 8'h10, 8'h20, 8'h35);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
